// File: rtl/sub_16bit_seq.sv
// sub_16bit_seq: multi-cycle W-bit subtractor computing z = x - y one 4-bit
// slice per clock (LSB first) with carry-lookahead slice logic, plus sign,
// zero, borrow, even-parity and signed-overflow flags.
// Optional feature macro: SUB16_SAT_EN (saturate z on signed overflow).
module sub_16bit_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] z,
  output logic         sign,
  output logic         zero,
  output logic         borrow,
  output logic         parity,
  output logic         overflow
);

  localparam int NS = W / 4;          // number of slice cycles
  localparam int CW = $clog2(NS);     // slice counter width (NS >= 2)

  // Reject widths the slice datapath cannot handle.
  if ((W < 8) || ((W % 4) != 0)) begin : g_bad_width
    $error("sub_16bit_seq: W must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;            // minuend, shifted right one slice per cycle
  logic [W-1:0]  b_q, b_d;            // ~subtrahend, shifted the same way
  logic          c_q, c_d;            // carry registered between slices
  logic [W-1:0]  acc_q, acc_d;        // result accumulated from the top down
  logic [W-1:0]  z_q, z_d;
  logic          sign_q, sign_d;
  logic          zero_q, zero_d;
  logic          borrow_q, borrow_d;
  logic          parity_q, parity_d;
  logic          ovf_q, ovf_d;

  logic [3:0]    g, p, cv;
  logic [3:0]    slice_sum;
  logic          slice_cout;
  logic [W-1:0]  z_raw, z_fin;
  logic          ovf_raw;
  logic          last_slice;
  logic          accept;

  // Carry-lookahead adder for the current 4-bit slice (a + ~y + carry).
  always_comb begin
    g          = a_q[3:0] & b_q[3:0];
    p          = a_q[3:0] ^ b_q[3:0];
    cv[0]      = c_q;
    cv[1]      = g[0] | (p[0] & c_q);
    cv[2]      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
    cv[3]      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_q);
    slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_q);
    slice_sum  = p ^ cv;
  end

  // Final result as seen during the last slice; on that cycle a_q[3]/b_q[3]
  // hold x[W-1] and ~y[W-1] because the operands have been shifted down.
  always_comb begin
    z_raw   = {slice_sum, acc_q[W-1:4]};
    ovf_raw = (a_q[3] ^ ~b_q[3]) & (z_raw[W-1] ^ a_q[3]);
`ifdef SUB16_SAT_EN
    if (ovf_raw) begin
      z_fin = a_q[3] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      z_fin = z_raw;
    end
`else
    z_fin = z_raw;
`endif
  end

  assign last_slice = (cnt_q == CW'(NS - 1));
  assign accept     = start && ((state_q == IDLE) || (state_q == DONE));

  // Next-state, datapath and result-register update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    acc_d    = acc_q;
    z_d      = z_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    borrow_d = borrow_q;
    parity_d = parity_q;
    ovf_d    = ovf_q;

    case (state_q)
      CALC: begin
        acc_d = z_raw;
        a_d   = {4'b0000, a_q[W-1:4]};
        b_d   = {4'b0000, b_q[W-1:4]};
        c_d   = slice_cout;
        cnt_d = cnt_q + 1'b1;
        if (last_slice) begin
          state_d  = DONE;
          z_d      = z_fin;
          sign_d   = z_fin[W-1];
          zero_d   = ~|z_fin;
          parity_d = ~^z_fin;
          borrow_d = ~slice_cout;
          ovf_d    = ovf_raw;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Start is honoured only in IDLE or DONE; in CALC it is ignored.
    if (accept) begin
      state_d = CALC;
      a_d     = x;
      b_d     = ~y;
      c_d     = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
    end
  end

  // State and data registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      acc_q    <= '0;
      z_q      <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      borrow_q <= 1'b0;
      parity_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      borrow_q <= borrow_d;
      parity_q <= parity_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign z        = z_q;
  assign sign     = sign_q;
  assign zero     = zero_q;
  assign borrow   = borrow_q;
  assign parity   = parity_q;
  assign overflow = ovf_q;

endmodule
